ahb_host_seq: RTL
=================

# ahb_host_seq

AHB master sequencer that sits directly upstream of the CPU's AHB slave interface and performs the whole bring-up: it streams the instruction image into instruction memory, initialises data memory, releases CPU reset, polls the CPU's done register, stops the CPU and reads back the accumulated result. It is the synthesizable replacement for the behavioural host tasks, so the CPU subsystem can run standalone on silicon or FPGA.

## Interface
Parameters:
- IM_BASE, 32'h40000000, instruction memory base address
- DM_BASE, 32'h40002000, data memory base address
- CPU_RSTN_ADDR, 32'h40008004, CPU run/reset control register
- RF6_ADDR, 32'h40004018, integer register x6 mirror (done flag)
- IM_WORDS, 29, number of instruction words to load
- ACC_NUM, 2046, accumulation count; header word written to DM_BASE is ACC_NUM*4
- DM_WORDS, 2047, fill words written from DM_BASE+4 onward
- DM_FILL, 32'h3f800000, fill value (1.0f)
- DONE_VAL, 32'd1234, x6 value meaning program finished
- POLL_MAX, 100000, maximum poll reads before timeout

Ports:
- HCLK  in  1  clock; all state updates on rising edge
- HRESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a sequence when idle
- in_valid  in  1  instruction word available
- in_data  in  32  instruction word
- in_ready  out  1  instruction word accepted this cycle when in_valid=1
- M_HADDR  out  32  transfer address
- M_HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ
- M_HWRITE  out  1  1=write, 0=read
- M_HWDATA  out  32  write data, driven in the same cycle as the address
- M_HREADY  in  1  slave ready; transfer completes in a cycle with NONSEQ and HREADY=1
- M_HRDATA  in  32  read data, valid the cycle after the read completes
- M_HRESP  in  1  error response on a completed transfer
- busy  out  1  sequence in progress
- done  out  1  held high in DONE until next start
- err  out  1  timeout or bus error occurred in the last sequence
- result  out  32  word read from DM_BASE + ACC_NUM*4 + 4

## Operation
- States: IDLE, LOAD_IM, DM_HDR, DM_FILL, CPU_GO, POLL_A, POLL_D, CPU_STOP, RD_A, RD_D, DONE.
- IDLE: HTRANS=IDLE; start -> LOAD_IM, clears err/done/result, word and poll counters to 0.
- LOAD_IM: in_ready = M_HREADY; when in_valid: NONSEQ write of in_data to IM_BASE+4*idx; if in_valid=0, HTRANS=IDLE. After IM_WORDS completions -> DM_HDR.
- DM_HDR: write ACC_NUM*4 to DM_BASE -> DM_FILL.
- DM_FILL: write DM_FILL to DM_BASE+4+4*idx, idx 0..DM_WORDS-1 -> CPU_GO.
- CPU_GO: write 1 to CPU_RSTN_ADDR -> POLL_A.
- POLL_A: read RF6_ADDR -> POLL_D. POLL_D: HTRANS=IDLE, sample M_HRDATA, poll_cnt+1; equal DONE_VAL -> CPU_STOP; else poll_cnt==POLL_MAX -> set err, CPU_STOP; else POLL_A.
- CPU_STOP: write 0 to CPU_RSTN_ADDR; -> RD_A if no err, else DONE (result stays 0).
- RD_A: read result address -> RD_D; RD_D samples M_HRDATA into result -> DONE.
- DONE: done=1, busy=0; start -> LOAD_IM (new sequence).
- M_HRESP=1 on any completed transfer: set err, go DONE immediately (CPU_RSTN not rewritten).
- Address arithmetic is 32-bit, wrap ignored; counters wide enough for max(IM_WORDS, DM_WORDS) and POLL_MAX.

## Timing
- Reset values: M_HTRANS=2'b00, M_HADDR=0, M_HWRITE=0, M_HWDATA=0, in_ready=0, busy=0, done=0, err=0, result=0, state IDLE.
- Bus outputs combinational from state/counters; no pipelining, one transfer in flight.
- M_HREADY=0 holds address, data and control stable; state and counters advance only on completion.
- Read data sampled exactly one cycle after the completing read cycle (POLL_D/RD_D), regardless of M_HREADY in that cycle.
- Unstalled latency: IM_WORDS + 1 + DM_WORDS + 1 + 2*polls + 1 + 2 cycles from start to done.
- start outside IDLE/DONE ignored. HRESET mid-sequence: next cycle IDLE, all outputs at reset values; CPU control register left as last written.

## Test plan
- Defaults, in_valid always 1, slave returns x6=1234 on 3rd poll -> 29 IM writes at 0x40000000..0x40000070, header 0x00001FF8 at 0x40002000, 2047 writes of 0x3f800000, 6 poll cycles, result read at 0x40003FFC, done=1, err=0, total 2087 cycles.
- in_valid toggling 1/0 and M_HREADY low for 2 cycles on IM word 5 -> no duplicate/dropped words, address held during stall, IM word order preserved.
- x6 never 1234, POLL_MAX=4 -> exactly 4 polls, write 0 to 0x40008004, err=1, result=0, done=1.
- M_HRESP=1 on DM_FILL word 10 -> err=1, DONE next cycle, no CPU_RSTN write.
- HRESET pulsed during DM_FILL -> HTRANS=IDLE next cycle, busy=0; subsequent start reruns full sequence from IM word 0.
- start pulsed while busy and again in DONE -> first ignored, second begins new sequence with err/done/result cleared.

Source files
------------

// File: rtl/ahb_host_seq_if.sv
// Instruction-stream and AHB master signals between the bring-up sequencer and the CPU slave port.
interface ahb_host_seq_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] M_HADDR;
  logic [1:0]  M_HTRANS;
  logic        M_HWRITE;
  logic [31:0] M_HWDATA;
  logic        M_HREADY;
  logic [31:0] M_HRDATA;
  logic        M_HRESP;

  modport master (
    input  in_valid, in_data, M_HREADY, M_HRDATA, M_HRESP,
    output in_ready, M_HADDR, M_HTRANS, M_HWRITE, M_HWDATA
  );

  modport slave (
    output in_valid, in_data, M_HREADY, M_HRDATA, M_HRESP,
    input  in_ready, M_HADDR, M_HTRANS, M_HWRITE, M_HWDATA
  );
endinterface

// File: rtl/ahb_host_seq.sv
// AHB bring-up sequencer: loads IM, initialises DM, runs the CPU, polls x6 and reads back the result.
// One transfer in flight; bus outputs are combinational from state/counters and held while HREADY=0.
module ahb_host_seq #(
  parameter logic [31:0] IM_BASE       = 32'h40000000,
  parameter logic [31:0] DM_BASE       = 32'h40002000,
  parameter logic [31:0] CPU_RSTN_ADDR = 32'h40008004,
  parameter logic [31:0] RF6_ADDR      = 32'h40004018,
  parameter int unsigned IM_WORDS      = 29,
  parameter int unsigned ACC_NUM       = 2046,
  parameter int unsigned DM_WORDS      = 2047,
  parameter logic [31:0] DM_FILL       = 32'h3f800000,
  parameter logic [31:0] DONE_VAL      = 32'd1234,
  parameter int unsigned POLL_MAX      = 100000
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               start,
  ahb_host_seq_if.master     bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        result
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD_IM  = 4'd1;
  localparam logic [3:0] S_DM_HDR   = 4'd2;
  localparam logic [3:0] S_DM_FILL  = 4'd3;
  localparam logic [3:0] S_CPU_GO   = 4'd4;
  localparam logic [3:0] S_POLL_A   = 4'd5;
  localparam logic [3:0] S_POLL_D   = 4'd6;
  localparam logic [3:0] S_CPU_STOP = 4'd7;
  localparam logic [3:0] S_RD_A     = 4'd8;
  localparam logic [3:0] S_RD_D     = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;
  localparam logic [31:0] HDR_VAL   = ACC_NUM * 4;
  localparam logic [31:0] RES_ADDR  = DM_BASE + HDR_VAL + 32'd4;

  logic [3:0]  state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] poll_q, poll_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;

  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        in_ready;
  logic        xfer_done;

  always_comb begin
    haddr    = 32'h0;
    htrans   = HT_IDLE;
    hwrite   = 1'b0;
    hwdata   = 32'h0;
    in_ready = 1'b0;
    case (state_q)
      S_LOAD_IM: begin
        in_ready = bus.M_HREADY;
        haddr    = IM_BASE + {idx_q[29:0], 2'b00};
        hwrite   = 1'b1;
        hwdata   = bus.in_data;
        htrans   = bus.in_valid ? HT_NONSEQ : HT_IDLE;
      end
      S_DM_HDR: begin
        haddr  = DM_BASE;
        hwrite = 1'b1;
        hwdata = HDR_VAL;
        htrans = HT_NONSEQ;
      end
      S_DM_FILL: begin
        haddr  = DM_BASE + 32'd4 + {idx_q[29:0], 2'b00};
        hwrite = 1'b1;
        hwdata = DM_FILL;
        htrans = HT_NONSEQ;
      end
      S_CPU_GO: begin
        haddr  = CPU_RSTN_ADDR;
        hwrite = 1'b1;
        hwdata = 32'd1;
        htrans = HT_NONSEQ;
      end
      S_POLL_A: begin
        haddr  = RF6_ADDR;
        htrans = HT_NONSEQ;
      end
      S_CPU_STOP: begin
        haddr  = CPU_RSTN_ADDR;
        hwrite = 1'b1;
        hwdata = 32'd0;
        htrans = HT_NONSEQ;
      end
      S_RD_A: begin
        haddr  = RES_ADDR;
        htrans = HT_NONSEQ;
      end
      default: ;
    endcase
  end

  assign xfer_done = (htrans == HT_NONSEQ) && bus.M_HREADY;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    poll_d   = poll_q;
    err_d    = err_q;
    result_d = result_q;
    // An error response aborts straight to DONE, so the CPU control register is left alone.
    if (xfer_done && bus.M_HRESP) begin
      err_d   = 1'b1;
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_LOAD_IM;
            idx_d    = 32'd0;
            poll_d   = 32'd0;
            err_d    = 1'b0;
            result_d = 32'd0;
          end
        end
        S_LOAD_IM: begin
          if (xfer_done) begin
            if (idx_q == IM_WORDS - 1) begin
              idx_d   = 32'd0;
              state_d = S_DM_HDR;
            end else begin
              idx_d = idx_q + 32'd1;
            end
          end
        end
        S_DM_HDR: if (xfer_done) state_d = S_DM_FILL;
        S_DM_FILL: begin
          if (xfer_done) begin
            if (idx_q == DM_WORDS - 1) begin
              idx_d   = 32'd0;
              state_d = S_CPU_GO;
            end else begin
              idx_d = idx_q + 32'd1;
            end
          end
        end
        S_CPU_GO: if (xfer_done) state_d = S_POLL_A;
        S_POLL_A: if (xfer_done) state_d = S_POLL_D;
        S_POLL_D: begin
          poll_d = poll_q + 32'd1;
          if (bus.M_HRDATA == DONE_VAL) begin
            state_d = S_CPU_STOP;
          end else if (poll_q + 32'd1 == POLL_MAX) begin
            err_d   = 1'b1;
            state_d = S_CPU_STOP;
          end else begin
            state_d = S_POLL_A;
          end
        end
        S_CPU_STOP: if (xfer_done) state_d = err_q ? S_DONE : S_RD_A;
        S_RD_A: if (xfer_done) state_d = S_RD_D;
        S_RD_D: begin
          result_d = bus.M_HRDATA;
          state_d  = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      idx_q    <= 32'd0;
      poll_q   <= 32'd0;
      err_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      poll_q   <= poll_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign bus.M_HADDR  = haddr;
  assign bus.M_HTRANS = htrans;
  assign bus.M_HWRITE = hwrite;
  assign bus.M_HWDATA = hwdata;
  assign bus.in_ready = in_ready;

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule
